// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, two write ports, issue strobe,
// per-port pending flags and the architectural register tap.
interface reg_file_mp_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADD_WIDTH  = 5,
   parameter int NUM_RD     = 2
);
   logic [NUM_RD*ADD_WIDTH-1:0]  AD;
   logic [NUM_RD*DATA_WIDTH-1:0] RD;
   logic                         WEA;
   logic [ADD_WIDTH-1:0]         ADA;
   logic [DATA_WIDTH-1:0]        WDA;
   logic                         WEB;
   logic [ADD_WIDTH-1:0]         ADB;
   logic [DATA_WIDTH-1:0]        WDB;
   logic                         ISS;
   logic [ADD_WIDTH-1:0]         ISS_AD;
   logic [NUM_RD-1:0]            BUSY;
   logic [DATA_WIDTH-1:0]        a0;

   modport master (
      output AD, WEA, ADA, WDA, WEB, ADB, WDB, ISS, ISS_AD,
      input  RD, BUSY, a0
   );

   modport slave (
      input  AD, WEA, ADA, WDA, WEB, ADB, WDB, ISS, ISS_AD,
      output RD, BUSY, a0
   );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD write-first synchronous reads, two write ports
// (A beats B), registered tap of TAP_ADDR. Optional pending scoreboard: REG_FILE_SCOREBOARD_EN.
module reg_file_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADD_WIDTH  = 5,
   parameter int NUM_RD     = 2,
   parameter int TAP_ADDR   = 10,
   parameter int ZERO_REG   = 1
) (
   input logic           clk,
   input logic           rst,
   reg_file_mp_if.slave  bus
);

   localparam int unsigned DEPTH = 1 << ADD_WIDTH;
   localparam logic [ADD_WIDTH-1:0] TAP = ADD_WIDTH'(TAP_ADDR);
   localparam bit ZERO_EN = (ZERO_REG != 0);

   logic [DATA_WIDTH-1:0]        r_mem [DEPTH];
   logic [NUM_RD*DATA_WIDTH-1:0] r_rd;
   logic [NUM_RD*DATA_WIDTH-1:0] w_rd_next;
   logic [DATA_WIDTH-1:0]        r_a0;
   logic [DATA_WIDTH-1:0]        w_a0_next;
   logic                         w_wea_ok;
   logic                         w_web_ok;

   // Value an address will hold after this edge's writes (write-first bypass).
   function automatic logic [DATA_WIDTH-1:0] fwd (
      input logic [ADD_WIDTH-1:0]  ad,
      input logic                  wea,
      input logic [ADD_WIDTH-1:0]  ada,
      input logic [DATA_WIDTH-1:0] wda,
      input logic                  web,
      input logic [ADD_WIDTH-1:0]  adb,
      input logic [DATA_WIDTH-1:0] wdb,
      input logic [DATA_WIDTH-1:0] stored
   );
      if (ZERO_EN && ad == '0)
         return '0;
      else if (wea && ada == ad)
         return wda;
      else if (web && adb == ad)
         return wdb;
      else
         return stored;
   endfunction

   // Port B is dropped when it collides with port A on the same address.
   always_comb begin
      w_wea_ok = bus.WEA && !(ZERO_EN && bus.ADA == '0);
      w_web_ok = bus.WEB && !(ZERO_EN && bus.ADB == '0)
                 && !(bus.WEA && bus.ADA == bus.ADB);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < DEPTH; k++)
            r_mem[k] <= '0;
      end else begin
         if (w_web_ok)
            r_mem[bus.ADB] <= bus.WDB;
         if (w_wea_ok)
            r_mem[bus.ADA] <= bus.WDA;
      end
   end

   always_comb begin
      w_rd_next = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         w_rd_next[i*DATA_WIDTH +: DATA_WIDTH] =
            fwd(bus.AD[i*ADD_WIDTH +: ADD_WIDTH], bus.WEA, bus.ADA, bus.WDA,
                bus.WEB, bus.ADB, bus.WDB, r_mem[bus.AD[i*ADD_WIDTH +: ADD_WIDTH]]);
      end
      w_a0_next = fwd(TAP, bus.WEA, bus.ADA, bus.WDA,
                      bus.WEB, bus.ADB, bus.WDB, r_mem[TAP]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd <= '0;
         r_a0 <= '0;
      end else begin
         r_rd <= w_rd_next;
         r_a0 <= w_a0_next;
      end
   end

   assign bus.RD = r_rd;
   assign bus.a0 = r_a0;

`ifdef REG_FILE_SCOREBOARD_EN
   logic [DEPTH-1:0]  r_pend;
   logic [DEPTH-1:0]  w_pend_next;
   logic [NUM_RD-1:0] r_busy;
   logic [NUM_RD-1:0] w_busy_next;

   // Clears applied before the set so a same-edge issue keeps the register pending.
   always_comb begin
      w_pend_next = r_pend;
      if (bus.WEB)
         w_pend_next[bus.ADB] = 1'b0;
      if (bus.WEA)
         w_pend_next[bus.ADA] = 1'b0;
      if (bus.ISS)
         w_pend_next[bus.ISS_AD] = 1'b1;
      if (ZERO_EN)
         w_pend_next[0] = 1'b0;
      w_busy_next = '0;
      for (int unsigned i = 0; i < NUM_RD; i++)
         w_busy_next[i] = w_pend_next[bus.AD[i*ADD_WIDTH +: ADD_WIDTH]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= '0;
         r_busy <= '0;
      end else begin
         r_pend <= w_pend_next;
         r_busy <= w_busy_next;
      end
   end

   assign bus.BUSY = r_busy;
`else
   logic w_unused_iss;
   assign w_unused_iss = ^{bus.ISS, bus.ISS_AD};
   assign bus.BUSY     = '0;
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: table of per-cycle vectors plus hand-written
// scoreboard/reset sequences; expectations are hand-computed.
module tb_reg_file_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
`ifdef REG_FILE_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   reg_file_mp_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .NUM_RD(NR)) bus ();

   reg_file_mp #(
      .DATA_WIDTH(DW),
      .ADD_WIDTH (AW),
      .NUM_RD    (NR),
      .TAP_ADDR  (10),
      .ZERO_REG  (1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          wea;
      logic [AW-1:0] ada;
      logic [DW-1:0] wda;
      logic          web;
      logic [AW-1:0] adb;
      logic [DW-1:0] wdb;
      logic [AW-1:0] ad0;
      logic [AW-1:0] ad1;
      logic [DW-1:0] e_rd0;
      logic [DW-1:0] e_rd1;
      logic [DW-1:0] e_a0;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic wea, input logic [AW-1:0] ada,
                        input logic [DW-1:0] wda, input logic web, input logic [AW-1:0] adb,
                        input logic [DW-1:0] wdb, input logic iss, input logic [AW-1:0] iss_ad,
                        input logic [AW-1:0] ad0, input logic [AW-1:0] ad1);
      rst        = r;
      bus.WEA    = wea;
      bus.ADA    = ada;
      bus.WDA    = wda;
      bus.WEB    = web;
      bus.ADB    = adb;
      bus.WDB    = wdb;
      bus.ISS    = iss;
      bus.ISS_AD = iss_ad;
      bus.AD     = {ad1, ad0};
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h0,        32'h0,        32'h0};
      vecs[1]  = '{1'b0, 1'b1, 5'd10, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd10, 5'd5,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
      vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd10, 5'd10, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[3]  = '{1'b0, 1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  32'h22,       5'd7,  5'd7,  32'h11,       32'h11,       32'hDEADBEEF};
      vecs[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd8,  32'h11,       32'h0,        32'hDEADBEEF};
      vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  32'h33,       5'd8,  5'd7,  32'h33,       32'h11,       32'hDEADBEEF};
      vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd8,  5'd10, 32'h33,       32'hDEADBEEF, 32'hDEADBEEF};
      vecs[7]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'hDEADBEEF};
      vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h12345678, 5'd0,  5'd10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
      vecs[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'hDEADBEEF};
      vecs[10] = '{1'b0, 1'b1, 5'd3,  32'h55,       1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  32'h55,       32'h0,        32'hDEADBEEF};
      vecs[11] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'hAA,       5'd3,  5'd10, 32'h0,        32'h0,        32'h0};
      vecs[12] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd10, 32'h0,        32'h0,        32'h0};
      vecs[13] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'hCAFEF00D, 5'd10, 5'd2,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D};
      vecs[14] = '{1'b0, 1'b1, 5'd12, 32'hAAAA5555, 1'b1, 5'd13, 32'h5555AAAA, 5'd13, 5'd12, 32'h5555AAAA, 32'hAAAA5555, 32'hCAFEF00D};
      vecs[15] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd12, 5'd13, 32'hAAAA5555, 32'h5555AAAA, 32'hCAFEF00D};

      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0);

      for (int v = 0; v < 16; v++) begin
         drive(vecs[v].rst, vecs[v].wea, vecs[v].ada, vecs[v].wda, vecs[v].web,
               vecs[v].adb, vecs[v].wdb, 1'b0, '0, vecs[v].ad0, vecs[v].ad1);
         chk($sformatf("v%0d.rd0", v), bus.RD[31:0],  vecs[v].e_rd0);
         chk($sformatf("v%0d.rd1", v), bus.RD[63:32], vecs[v].e_rd1);
         chk($sformatf("v%0d.a0", v),  bus.a0,        vecs[v].e_a0);
         chk($sformatf("v%0d.busy", v), DW'(bus.BUSY), '0);
      end

      // Issue register 4: pending only when the scoreboard is built.
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4, 5'd4, 5'd0);
      chk("sb_issue.busy", DW'(bus.BUSY), DW'({1'b0, SB}));
      chk("sb_issue.rd0",  bus.RD[31:0], 32'h0);

      // Issue and write on the same register: set wins, data still bypasses.
      drive(1'b0, 1'b1, 5'd4, 32'h77, 1'b0, '0, '0, 1'b1, 5'd4, 5'd4, 5'd4);
      chk("sb_setwins.busy", DW'(bus.BUSY), DW'({SB, SB}));
      chk("sb_setwins.rd0",  bus.RD[31:0], 32'h77);

      // Write alone retires the producer.
      drive(1'b0, 1'b1, 5'd4, 32'h99, 1'b0, '0, '0, 1'b0, '0, 5'd4, 5'd4);
      chk("sb_clear.busy", DW'(bus.BUSY), '0);
      chk("sb_clear.rd0",  bus.RD[31:0], 32'h99);
      chk("sb_clear.rd1",  bus.RD[63:32], 32'h99);

      // Register 0 is never pending.
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0, 5'd0, 5'd4);
      chk("sb_zero.busy", DW'(bus.BUSY), '0);

      // Issue on 9 with port-B write to 9 on the same edge: set still wins.
      drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h1234, 1'b1, 5'd9, 5'd9, 5'd4);
      chk("sb_setb.busy", DW'(bus.BUSY), DW'({1'b0, SB}));
      chk("sb_setb.rd0",  bus.RD[31:0], 32'h1234);

      // Reset clears data, tap and pending state.
      drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd10);
      chk("rst_end.busy", DW'(bus.BUSY), '0);
      chk("rst_end.rd0",  bus.RD[31:0], 32'h0);
      chk("rst_end.a0",   bus.a0, 32'h0);

      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd4);
      chk("post_rst.busy", DW'(bus.BUSY), '0);
      chk("post_rst.rd0",  bus.RD[31:0], 32'h0);
      chk("post_rst.rd1",  bus.RD[63:32], 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
